// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS hazard unit: opcode/funct codes,
// instruction classes, Tuse/Tnew values, forward-select codes and shadow-stage record.
package hazard_pkg;

   localparam int             RA_W     = 5;
   localparam logic [RA_W-1:0] LINK_REG = 5'd31;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
                          OP_BNE     = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                          OP_SLTI    = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c,
                          OP_ORI     = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
                          OP_LW      = 6'h23, OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                          FN_JR  = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20,
                          FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                          FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26,
                          FN_NOR = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

   typedef enum logic [3:0] {
      CLS_NONE, CLS_B, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_JAL, CLS_JR, CLS_JALR
   } cls_e;

   localparam logic [1:0] TUSE_0 = 2'd0, TUSE_1 = 2'd1, TUSE_2 = 2'd2;
   localparam logic [1:0] TNEW_0 = 2'd0, TNEW_1 = 2'd1, TNEW_2 = 2'd2;

   localparam logic [1:0] FWD_RF = 2'b00, FWD_E = 2'b01, FWD_M = 2'b10, FWD_W = 2'b11;

   typedef struct packed {
      cls_e            cls;
      logic [RA_W-1:0] rs;
      logic [RA_W-1:0] rt;
      logic [RA_W-1:0] dst;
      logic [1:0]      tnew;
   } stage_t;

   localparam stage_t BUBBLE = '{cls: CLS_NONE, rs: '0, rt: '0, dst: '0, tnew: TNEW_0};

   function automatic logic [1:0] tnew_step(input logic [1:0] t);
      return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
   endfunction

   // Nearest producer wins; pass e='0 for consumers that have no E-stage producer.
   function automatic logic [1:0] fwd_pick(input logic [RA_W-1:0] src, e, m, w);
      if (src == '0) return FWD_RF;
      if (src == e)  return FWD_E;
      if (src == m)  return FWD_M;
      if (src == w)  return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_dec.sv
// Combinational instruction classifier: class, source regs with Tuse,
// destination reg and Tnew on entering E.
module instr_class_dec
   import hazard_pkg::*;
(
   input  logic [31:0]     ir_i,
   output cls_e            cls_o,
   output logic [RA_W-1:0] rs_o,
   output logic [RA_W-1:0] rt_o,
   output logic [RA_W-1:0] dst_o,
   output logic [1:0]      tuse_rs_o,
   output logic [1:0]      tuse_rt_o,
   output logic            use_rs_o,
   output logic            use_rt_o,
   output logic [1:0]      tnew_e_o
);

   logic [5:0]      op, fn;
   logic [RA_W-1:0] rd;
   logic            is_shift;
   logic            unused_shamt;

   assign op           = ir_i[31:26];
   assign fn           = ir_i[5:0];
   assign rs_o         = ir_i[25:21];
   assign rt_o         = ir_i[20:16];
   assign rd           = ir_i[15:11];
   assign is_shift     = (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
   assign unused_shamt = ^ir_i[10:6];

   always_comb begin
      cls_o     = CLS_NONE;
      use_rs_o  = 1'b0;
      use_rt_o  = 1'b0;
      tuse_rs_o = TUSE_0;
      tuse_rt_o = TUSE_0;
      dst_o     = '0;
      tnew_e_o  = TNEW_0;

      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls_o = CLS_CAL_R;
               FN_JR:   cls_o = CLS_JR;
               FN_JALR: cls_o = CLS_JALR;
               default: cls_o = CLS_NONE;
            endcase
         end
         OP_BEQ, OP_BNE: cls_o = CLS_B;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls_o = CLS_CAL_I;
         OP_LW:   cls_o = CLS_LOAD;
         OP_SW:   cls_o = CLS_STORE;
         OP_JAL:  cls_o = CLS_JAL;
         default: cls_o = CLS_NONE;
      endcase

      case (cls_o)
         CLS_B: begin
            use_rs_o = 1'b1;
            use_rt_o = 1'b1;
         end
         CLS_CAL_R: begin
            use_rs_o  = !is_shift;
            use_rt_o  = 1'b1;
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_1;
            dst_o     = rd;
            tnew_e_o  = TNEW_1;
         end
         CLS_CAL_I: begin
            use_rs_o  = (op != OP_LUI);
            tuse_rs_o = TUSE_1;
            dst_o     = rt_o;
            tnew_e_o  = TNEW_1;
         end
         CLS_LOAD: begin
            use_rs_o  = 1'b1;
            tuse_rs_o = TUSE_1;
            dst_o     = rt_o;
            tnew_e_o  = TNEW_2;
         end
         CLS_STORE: begin
            use_rs_o  = 1'b1;
            use_rt_o  = 1'b1;
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_2;
         end
         CLS_JAL:  dst_o = LINK_REG;
         CLS_JR:   use_rs_o = 1'b1;
         CLS_JALR: begin
            use_rs_o = 1'b1;
            dst_o    = rd;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit top: shadow E/M/W records, Tuse/Tnew stall check and
// forward-select priority muxes for the D, E and M consumers.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     ir_d,
   output logic            stall,
   output logic [1:0]      fwd_rs_d,
   output logic [1:0]      fwd_rt_d,
   output logic [1:0]      fwd_rs_e,
   output logic [1:0]      fwd_rt_e,
   output logic [1:0]      fwd_rt_m,
   output logic [RA_W-1:0] dst_e,
   output logic [RA_W-1:0] dst_m,
   output logic [RA_W-1:0] dst_w
);

   cls_e            d_cls;
   logic [RA_W-1:0] d_rs_raw, d_rt_raw, d_rs, d_rt, d_dst;
   logic [1:0]      d_tuse_rs, d_tuse_rt, d_tnew;
   logic            d_use_rs, d_use_rt;

   stage_t e_q, m_q, w_q, e_d, m_d, w_d;
   logic   unused_dbg;

   instr_class_dec u_dec (
      .ir_i      (ir_d),
      .cls_o     (d_cls),
      .rs_o      (d_rs_raw),
      .rt_o      (d_rt_raw),
      .dst_o     (d_dst),
      .tuse_rs_o (d_tuse_rs),
      .tuse_rt_o (d_tuse_rt),
      .use_rs_o  (d_use_rs),
      .use_rt_o  (d_use_rt),
      .tnew_e_o  (d_tnew)
   );

   // Unread source fields collapse to $0 so they can neither stall nor forward.
   assign d_rs = d_use_rs ? d_rs_raw : '0;
   assign d_rt = d_use_rt ? d_rt_raw : '0;

   function automatic logic not_ready(input logic [RA_W-1:0] src, input logic [1:0] tuse,
                                      input stage_t e, input stage_t m);
      return (src != '0) &&
             (((src == e.dst) && (e.tnew > tuse)) || ((src == m.dst) && (m.tnew > tuse)));
   endfunction

   assign stall = not_ready(d_rs, d_tuse_rs, e_q, m_q) || not_ready(d_rt, d_tuse_rt, e_q, m_q);

   assign fwd_rs_d = fwd_pick(d_rs, e_q.dst, m_q.dst, w_q.dst);
   assign fwd_rt_d = fwd_pick(d_rt, e_q.dst, m_q.dst, w_q.dst);
   assign fwd_rs_e = fwd_pick(e_q.rs, '0, m_q.dst, w_q.dst);
   assign fwd_rt_e = fwd_pick(e_q.rt, '0, m_q.dst, w_q.dst);
   assign fwd_rt_m = fwd_pick(m_q.rt, '0, '0, w_q.dst);

   assign dst_e = e_q.dst;
   assign dst_m = m_q.dst;
   assign dst_w = w_q.dst;

   // Class and W-stage fields are kept for datapath debug only.
   assign unused_dbg = ^{e_q.cls, m_q.cls, m_q.rs, w_q.cls, w_q.rs, w_q.rt, w_q.tnew};

   always_comb begin
      e_d = BUBBLE;
      if (!stall) e_d = '{cls: d_cls, rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew};
      m_d      = e_q;
      m_d.tnew = tnew_step(e_q.tnew);
      w_d      = m_q;
      w_d.tnew = tnew_step(m_q.tnew);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q <= BUBBLE;
         m_q <= BUBBLE;
         w_q <= BUBBLE;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction-level model of E/M/W compared
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir_d = 32'h0;
   logic        stall;
   logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
   logic [4:0]  dst_e, dst_m, dst_w;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] LW8     = 32'h8C08_0000; // lw $8,0($0)
   localparam logic [31:0] ADDU9   = 32'h0100_4821; // addu $9,$8,$0
   localparam logic [31:0] ADDU3   = 32'h0022_1821; // addu $3,$1,$2
   localparam logic [31:0] BEQ3    = 32'h1060_0004; // beq $3,$0,4
   localparam logic [31:0] JAL     = 32'h0C00_0010;
   localparam logic [31:0] JR31    = 32'h03E0_0008;
   localparam logic [31:0] LW5     = 32'h8C05_0000; // lw $5,0($0)
   localparam logic [31:0] SW5     = 32'hAC05_0004; // sw $5,4($0)
   localparam logic [31:0] LW0     = 32'h8C00_0000; // lw $0,0($0)
   localparam logic [31:0] ADDU900 = 32'h0000_4821; // addu $9,$0,$0
   localparam logic [31:0] LUI8    = 32'h3C08_0001; // lui $8,1

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .ir_d(ir_d), .stall(stall),
      .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
      .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
      .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w)
   );

   always #5 clk = ~clk;

   // ---------------- instruction-level model ----------------
   // Unused sources are reported as reg 0. tn is Tnew on entering E.
   function automatic void mdec(input logic [31:0] ir,
                                output logic [4:0] s0, output int u0,
                                output logic [4:0] s1, output int u1,
                                output logic [4:0] d, output int tn);
      logic [5:0] op, fn;
      op = ir[31:26]; fn = ir[5:0];
      s0 = 0; s1 = 0; u0 = 0; u1 = 0; d = 0; tn = 0;
      case (op)
         6'h00: case (fn)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
               s0 = ir[25:21]; u0 = 1; s1 = ir[20:16]; u1 = 1; d = ir[15:11]; tn = 1; end
            6'h00, 6'h02, 6'h03: begin s1 = ir[20:16]; u1 = 1; d = ir[15:11]; tn = 1; end
            6'h08: s0 = ir[25:21];
            6'h09: begin s0 = ir[25:21]; d = ir[15:11]; end
            default: ;
         endcase
         6'h04, 6'h05: begin s0 = ir[25:21]; s1 = ir[20:16]; end
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
            s0 = ir[25:21]; u0 = 1; d = ir[20:16]; tn = 1; end
         6'h0f: begin d = ir[20:16]; tn = 1; end
         6'h23: begin s0 = ir[25:21]; u0 = 1; d = ir[20:16]; tn = 2; end
         6'h2b: begin s0 = ir[25:21]; u0 = 1; s1 = ir[20:16]; u1 = 2; end
         6'h03: d = 5'd31;
         default: ;
      endcase
   endfunction

   // m_ir[0]=E, [1]=M, [2]=W; m_v marks a real instruction (not a bubble).
   logic [31:0] m_ir [3];
   bit          m_v  [3] = '{0, 0, 0};

   function automatic logic [4:0] mdst(input int i);
      logic [4:0] s0, s1, d; int u0, u1, tn;
      mdec(m_ir[i], s0, u0, s1, u1, d, tn);
      return m_v[i] ? d : 5'd0;
   endfunction

   // Cycles still needed before stage i's result exists.
   function automatic int mtnew(input int i);
      logic [4:0] s0, s1, d; int u0, u1, tn;
      mdec(m_ir[i], s0, u0, s1, u1, d, tn);
      return (tn - i > 0) ? tn - i : 0;
   endfunction

   // Forward code equals (stage index + 1) of the nearest producer at or after 'first'.
   function automatic logic [1:0] near(input logic [4:0] s, input int first);
      if (s == 0) return 2'b00;
      for (int i = first; i < 3; i++)
         if (m_v[i] && mdst(i) == s) return 2'(i + 1);
      return 2'b00;
   endfunction

   function automatic bit mblocked(input logic [4:0] s, input int u);
      if (s == 0) return 1'b0;
      for (int i = 0; i < 2; i++)
         if (m_v[i] && mdst(i) == s && mtnew(i) > u) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit mstall(input logic [31:0] ir);
      logic [4:0] s0, s1, d; int u0, u1, tn;
      mdec(ir, s0, u0, s1, u1, d, tn);
      return mblocked(s0, u0) || mblocked(s1, u1);
   endfunction

   function automatic logic [4:0] msrc(input int i, input bit rt);
      logic [4:0] s0, s1, d; int u0, u1, tn;
      mdec(m_ir[i], s0, u0, s1, u1, d, tn);
      if (!m_v[i]) return 5'd0;
      return rt ? s1 : s0;
   endfunction

   function automatic logic [4:0] dsrc(input logic [31:0] ir, input bit rt);
      logic [4:0] s0, s1, d; int u0, u1, tn;
      mdec(ir, s0, u0, s1, u1, d, tn);
      return rt ? s1 : s0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_v[0] <= 1'b0; m_v[1] <= 1'b0; m_v[2] <= 1'b0;
      end else begin
         m_ir[2] <= m_ir[1]; m_v[2] <= m_v[1];
         m_ir[1] <= m_ir[0]; m_v[1] <= m_v[0];
         m_ir[0] <= ir_d;    m_v[0] <= !mstall(ir_d);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_stall",    32'(stall),    32'(mstall(ir_d)));
         chk("m_fwd_rs_d", 32'(fwd_rs_d), 32'(near(dsrc(ir_d, 1'b0), 0)));
         chk("m_fwd_rt_d", 32'(fwd_rt_d), 32'(near(dsrc(ir_d, 1'b1), 0)));
         chk("m_fwd_rs_e", 32'(fwd_rs_e), 32'(near(msrc(0, 1'b0), 1)));
         chk("m_fwd_rt_e", 32'(fwd_rt_e), 32'(near(msrc(0, 1'b1), 1)));
         chk("m_fwd_rt_m", 32'(fwd_rt_m), 32'(near(msrc(1, 1'b1), 2)));
         chk("m_dst_e",    32'(dst_e),    32'(mdst(0)));
         chk("m_dst_m",    32'(dst_m),    32'(mdst(1)));
         chk("m_dst_w",    32'(dst_w),    32'(mdst(2)));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input logic [31:0] ir, input logic rst);
      @(posedge clk); #1;
      ir_d  = ir;
      reset = rst;
      @(negedge clk);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) cyc(NOP, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      cyc(NOP, 1'b1);
      cyc(NOP, 1'b1);
      chk_en = 1'b1;
      cyc(NOP, 1'b0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_fwd",   32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 32'd0);
      chk("rst_dst",   32'({dst_e, dst_m, dst_w}), 32'd0);

      // load-use: one stall, then M forward in D, then W forward in E
      cyc(LW8, 1'b0);    chk("lu_nostall", 32'(stall), 32'd0);
      cyc(ADDU9, 1'b0);  chk("lu_stall",   32'(stall), 32'd1);
      cyc(ADDU9, 1'b0);  chk("lu_release", 32'(stall), 32'd0);
                         chk("lu_fwd_d",   32'(fwd_rs_d), 32'd2);
      cyc(NOP, 1'b0);    chk("lu_fwd_e",   32'(fwd_rs_e), 32'd3);
                         chk("lu_dst_e",   32'(dst_e), 32'd9);
                         chk("lu_dst_w",   32'(dst_w), 32'd8);
      flush();

      // ALU result into a branch
      cyc(ADDU3, 1'b0);
      cyc(BEQ3, 1'b0);   chk("br_stall", 32'(stall), 32'd1);
      cyc(BEQ3, 1'b0);   chk("br_go",    32'(stall), 32'd0);
                         chk("br_fwd",   32'(fwd_rs_d), 32'd2);
      flush();

      // ALU result reaches a branch from W
      cyc(ADDU3, 1'b0);
      cyc(NOP, 1'b0);
      cyc(NOP, 1'b0);
      cyc(BEQ3, 1'b0);   chk("brw_stall", 32'(stall), 32'd0);
                         chk("brw_fwd",   32'(fwd_rs_d), 32'd3);
      flush();

      // jal link value straight from E
      cyc(JAL, 1'b0);
      cyc(JR31, 1'b0);   chk("jr_stall", 32'(stall), 32'd0);
                         chk("jr_fwd",   32'(fwd_rs_d), 32'd1);
      flush();

      // lui result consumed at Tuse 1 needs no stall
      cyc(LUI8, 1'b0);
      cyc(ADDU9, 1'b0);  chk("lui_stall", 32'(stall), 32'd0);
                         chk("lui_fwd",   32'(fwd_rs_d), 32'd1);
      flush();

      // load feeding store data: no stall, forwarded late
      cyc(LW5, 1'b0);
      cyc(SW5, 1'b0);    chk("st_stall", 32'(stall), 32'd0);
                         chk("st_fwd_d", 32'(fwd_rt_d), 32'd1);
      cyc(NOP, 1'b0);    chk("st_fwd_e", 32'(fwd_rt_e), 32'd2);
      cyc(NOP, 1'b0);    chk("st_fwd_m", 32'(fwd_rt_m), 32'd3);
      flush();

      // $0 never stalls or forwards
      cyc(LW0, 1'b0);
      cyc(ADDU900, 1'b0); chk("r0_stall", 32'(stall), 32'd0);
                          chk("r0_fwd",   32'({fwd_rs_d, fwd_rt_d}), 32'd0);
      cyc(NOP, 1'b0);     chk("r0_fwd_e", 32'({fwd_rs_e, fwd_rt_e}), 32'd0);
      flush();

      // reset during a load-use stall
      cyc(LW8, 1'b0);
      cyc(ADDU9, 1'b1);  chk("rs_stall_in", 32'(stall), 32'd1);
      cyc(ADDU9, 1'b0);  chk("rs_stall",    32'(stall), 32'd0);
                         chk("rs_dst",      32'({dst_e, dst_m, dst_w}), 32'd0);
      flush();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
